// File: rtl/uart_cfg_if.sv
// uart_cfg_if: host-side bus of the uart_cfg UART core.
//   master modport: command-parser side (drives writes/reads/clear, sees status)
//   slave modport : UART side
//   wr_uart/w_data  push a byte into the TX FIFO; tx_full, tx_busy report TX state
//   rd_uart/r_data  pop the RX FIFO (r_data is the first-word-fall-through head)
//   rx_empty        RX FIFO empty
//   frame_err, parity_err, overrun  sticky error flags; err_clr clears them
interface uart_cfg_if #(
    parameter int DBIT = 8
);
    logic            wr_uart;
    logic [DBIT-1:0] w_data;
    logic            tx_full;
    logic            tx_busy;
    logic            rd_uart;
    logic [DBIT-1:0] r_data;
    logic            rx_empty;
    logic            frame_err;
    logic            parity_err;
    logic            overrun;
    logic            err_clr;

    modport master (
        output wr_uart, w_data, rd_uart, err_clr,
        input  tx_full, tx_busy, r_data, rx_empty, frame_err, parity_err, overrun
    );

    modport slave (
        input  wr_uart, w_data, rd_uart, err_clr,
        output tx_full, tx_busy, r_data, rx_empty, frame_err, parity_err, overrun
    );
endinterface

// File: rtl/uart_cfg.sv
// uart_cfg: UART core for the DDS control link.
//   Baud tick generator (run-time divisor), 16x-oversampling receiver,
//   transmitter with optional even/odd parity and 1/2 stop bits, RX and TX
//   FIFOs (2^FIFO_W words, first-word-fall-through) and sticky error flags.
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   dvsr               oversample tick period in clk cycles (min effective 2)
//   parity_mode        00/11 none, 01 even, 10 odd (latched per frame)
//   stop2              TX stop length: 0 = 16 ticks, 1 = 32 ticks (latched per frame)
//   rx, tx             serial pins, idle high
//   bus                uart_cfg_if slave modport (FIFO access, status, errors)
//   loopback           only when UART_LOOPBACK_EN is defined: internal tx feeds
//                      the receiver and the tx pin is held high
module uart_cfg_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [W-1:0] w_data,
    input  logic         rd,
    output logic [W-1:0] r_data,
    output logic         empty,
    output logic         full
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_wr;
    logic         do_rd;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd  = rd && !empty;
    // A write while full is accepted only when a pop frees the slot in the same clk.
    assign do_wr  = wr && (!full || do_rd);
    assign r_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '{default: '0};
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= w_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end
endmodule

module uart_cfg #(
    parameter int DBIT     = 8,
    parameter int FIFO_W   = 2,
    parameter int DVSR_BIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic [1:0]          parity_mode,
    input  logic                stop2,
    input  logic                rx,
    output logic                tx,
    uart_cfg_if.slave           bus
`ifdef UART_LOOPBACK_EN
    ,
    input  logic                loopback
`endif
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} frame_state_t;

    localparam logic [2:0] LAST_BIT = 3'(DBIT - 1);

    // ---------------- baud tick ----------------
    logic [DVSR_BIT-1:0] baud_cnt;
    logic [DVSR_BIT-1:0] baud_lim;
    logic                baud_tick;

    assign baud_tick = (baud_cnt == baud_lim);

    // The wrap limit is reloaded from dvsr only at wrap, so a divisor change
    // never truncates a running period; after reset the first period is 2 clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            baud_lim <= DVSR_BIT'(1);
        end else if (baud_tick) begin
            baud_cnt <= '0;
            baud_lim <= (dvsr < DVSR_BIT'(2)) ? DVSR_BIT'(1) : dvsr - DVSR_BIT'(1);
        end else begin
            baud_cnt <= baud_cnt + DVSR_BIT'(1);
        end
    end

    // ---------------- pin routing ----------------
    logic tx_q;
    logic rx_src;
`ifdef UART_LOOPBACK_EN
    assign tx     = loopback ? 1'b1 : tx_q;
    assign rx_src = loopback ? tx_q : rx;
`else
    assign tx     = tx_q;
    assign rx_src = rx;
`endif

    logic rx_meta;
    logic rx_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_src;
            rx_sync <= rx_meta;
        end
    end

    // ---------------- FIFOs ----------------
    logic            tx_empty;
    logic            tx_pop;
    logic [DBIT-1:0] tx_head;
    logic            rx_full;
    logic            rx_push;
    logic [DBIT-1:0] rx_b;

    uart_cfg_fifo #(.W(DBIT), .AW(FIFO_W)) tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (bus.wr_uart),
        .w_data (bus.w_data),
        .rd     (tx_pop),
        .r_data (tx_head),
        .empty  (tx_empty),
        .full   (bus.tx_full)
    );

    // A push into a full RX FIFO is dropped here (and flagged as overrun), even
    // if the host pops in the same clk.
    uart_cfg_fifo #(.W(DBIT), .AW(FIFO_W)) rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (rx_push && !rx_full),
        .w_data (rx_b),
        .rd     (bus.rd_uart),
        .r_data (bus.r_data),
        .empty  (bus.rx_empty),
        .full   (rx_full)
    );

    // ---------------- transmitter ----------------
    frame_state_t    tx_state, tx_state_n;
    logic [4:0]      tx_s, tx_s_n;
    logic [2:0]      tx_n, tx_n_n;
    logic [DBIT-1:0] tx_b, tx_b_n;
    logic            tx_q_n;
    logic            tx_par, tx_par_n;
    logic            tx_pen, tx_pen_n;
    logic            tx_stop2, tx_stop2_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
            tx_q     <= 1'b1;
            tx_par   <= 1'b0;
            tx_pen   <= 1'b0;
            tx_stop2 <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_s     <= tx_s_n;
            tx_n     <= tx_n_n;
            tx_b     <= tx_b_n;
            tx_q     <= tx_q_n;
            tx_par   <= tx_par_n;
            tx_pen   <= tx_pen_n;
            tx_stop2 <= tx_stop2_n;
        end
    end

    // tx_q is registered: each branch sets the level of the bit being entered.
    always_comb begin
        tx_state_n = tx_state;
        tx_s_n     = tx_s;
        tx_n_n     = tx_n;
        tx_b_n     = tx_b;
        tx_q_n     = tx_q;
        tx_par_n   = tx_par;
        tx_pen_n   = tx_pen;
        tx_stop2_n = tx_stop2;
        tx_pop     = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_q_n = 1'b1;
                if (!tx_empty) begin
                    tx_state_n = START;
                    tx_s_n     = '0;
                    tx_b_n     = tx_head;
                    tx_q_n     = 1'b0;
                    tx_pen_n   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    tx_par_n   = (^tx_head) ^ (parity_mode == 2'b10);
                    tx_stop2_n = stop2;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tx_s == 5'd15) begin
                        tx_state_n = DATA;
                        tx_s_n     = '0;
                        tx_n_n     = '0;
                        tx_q_n     = tx_b[0];
                    end else begin
                        tx_s_n = tx_s + 5'd1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tx_s == 5'd15) begin
                        tx_s_n = '0;
                        tx_b_n = tx_b >> 1;
                        if (tx_n == LAST_BIT) begin
                            tx_state_n = tx_pen ? PARITY : STOP;
                            tx_q_n     = tx_pen ? tx_par : 1'b1;
                        end else begin
                            tx_n_n = tx_n + 3'd1;
                            tx_q_n = tx_b[1];
                        end
                    end else begin
                        tx_s_n = tx_s + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    if (tx_s == 5'd15) begin
                        tx_state_n = STOP;
                        tx_s_n     = '0;
                        tx_q_n     = 1'b1;
                    end else begin
                        tx_s_n = tx_s + 5'd1;
                    end
                end
            end
            STOP: begin
                tx_q_n = 1'b1;
                if (baud_tick) begin
                    if (tx_s == (tx_stop2 ? 5'd31 : 5'd15)) begin
                        tx_state_n = IDLE;
                        tx_s_n     = '0;
                        tx_pop     = 1'b1;
                    end else begin
                        tx_s_n = tx_s + 5'd1;
                    end
                end
            end
            default: begin
                tx_state_n = IDLE;
                tx_q_n     = 1'b1;
            end
        endcase
    end

    assign bus.tx_busy = (tx_state != IDLE) || !tx_empty;

    // ---------------- receiver ----------------
    frame_state_t    rx_state, rx_state_n;
    logic [3:0]      rx_s, rx_s_n;
    logic [2:0]      rx_n, rx_n_n;
    logic [DBIT-1:0] rx_b_n;
    logic            rx_pen, rx_pen_n;
    logic            rx_odd, rx_odd_n;
    logic            set_fe;
    logic            set_pe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            rx_b     <= '0;
            rx_pen   <= 1'b0;
            rx_odd   <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_s     <= rx_s_n;
            rx_n     <= rx_n_n;
            rx_b     <= rx_b_n;
            rx_pen   <= rx_pen_n;
            rx_odd   <= rx_odd_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_s_n     = rx_s;
        rx_n_n     = rx_n;
        rx_b_n     = rx_b;
        rx_pen_n   = rx_pen;
        rx_odd_n   = rx_odd;
        rx_push    = 1'b0;
        set_fe     = 1'b0;
        set_pe     = 1'b0;
        case (rx_state)
            IDLE: begin
                if (!rx_sync) begin
                    rx_state_n = START;
                    rx_s_n     = '0;
                    rx_pen_n   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    rx_odd_n   = (parity_mode == 2'b10);
                end
            end
            START: begin
                // Resample near the middle of the start bit; high means a glitch.
                if (baud_tick) begin
                    if (rx_s == 4'd7) begin
                        rx_s_n     = '0;
                        rx_n_n     = '0;
                        rx_state_n = rx_sync ? IDLE : DATA;
                    end else begin
                        rx_s_n = rx_s + 4'd1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (rx_s == 4'd15) begin
                        rx_s_n = '0;
                        rx_b_n = {rx_sync, rx_b[DBIT-1:1]};
                        if (rx_n == LAST_BIT) begin
                            rx_state_n = rx_pen ? PARITY : STOP;
                        end else begin
                            rx_n_n = rx_n + 3'd1;
                        end
                    end else begin
                        rx_s_n = rx_s + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    if (rx_s == 4'd15) begin
                        rx_s_n     = '0;
                        rx_state_n = STOP;
                        set_pe     = rx_sync != ((^rx_b) ^ rx_odd);
                    end else begin
                        rx_s_n = rx_s + 4'd1;
                    end
                end
            end
            STOP: begin
                // Only the first stop bit is checked; a second one is idle time.
                if (baud_tick) begin
                    if (rx_s == 4'd15) begin
                        rx_s_n     = '0;
                        rx_state_n = IDLE;
                        rx_push    = 1'b1;
                        set_fe     = !rx_sync;
                    end else begin
                        rx_s_n = rx_s + 4'd1;
                    end
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

    // ---------------- sticky error flags (set beats clear) ----------------
    logic frame_err_q;
    logic parity_err_q;
    logic overrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= set_fe | (frame_err_q & ~bus.err_clr);
            parity_err_q <= set_pe | (parity_err_q & ~bus.err_clr);
            overrun_q    <= (rx_push & rx_full) | (overrun_q & ~bus.err_clr);
        end
    end

    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_cfg.sv
module tb_uart_cfg;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dvsr;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic        rx;
    logic        tx;
`ifdef UART_LOOPBACK_EN
    logic        loopback;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_cfg_if #(.DBIT(8)) bus ();

    uart_cfg #(.DBIT(8), .FIFO_W(2), .DVSR_BIT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .dvsr        (dvsr),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .rx          (rx),
        .tx          (tx),
        .bus         (bus)
`ifdef UART_LOOPBACK_EN
        ,
        .loopback    (loopback)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tx(input logic [7:0] d);
        bus.w_data  = d;
        bus.wr_uart = 1'b1;
        @(negedge clk);
        bus.wr_uart = 1'b0;
    endtask

    task automatic pop_rx();
        bus.rd_uart = 1'b1;
        @(negedge clk);
        bus.rd_uart = 1'b0;
    endtask

    task automatic clear_errors();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        @(negedge clk);
    endtask

    // 64 clk per bit at dvsr=4. A low stop bit is kept short so the receiver
    // does not mistake its tail for a new start bit.
    task automatic rx_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic sbit);
        rx = 1'b0;
        wait_clk(64);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(64);
        end
        if (pen) begin
            rx = pbit;
            wait_clk(64);
        end
        if (sbit) begin
            rx = 1'b1;
            wait_clk(96);
        end else begin
            rx = 1'b0;
            wait_clk(48);
            rx = 1'b1;
            wait_clk(112);
        end
    endtask

    initial begin
        int t;
        int d;
        int start_cyc;
        int busy_cyc;
        int tx_low;
        logic [9:0] txexp;

        reset          = 1'b1;
        dvsr           = 16'd4;
        parity_mode    = 2'b01;
        stop2          = 1'b0;
        rx             = 1'b1;
        bus.wr_uart    = 1'b0;
        bus.w_data     = '0;
        bus.rd_uart    = 1'b0;
        bus.err_clr    = 1'b0;
`ifdef UART_LOOPBACK_EN
        loopback       = 1'b0;
`endif
        wait_clk(4);
        reset = 1'b0;
        wait_clk(2);

        // reset state
        check("rst_tx", tx, 1);
        check("rst_tx_busy", bus.tx_busy, 0);
        check("rst_tx_full", bus.tx_full, 0);
        check("rst_rx_empty", bus.rx_empty, 1);
        check("rst_r_data", bus.r_data, 0);
        check("rst_errs", {bus.frame_err, bus.parity_err, bus.overrun}, 0);

        // TX 0xA5, even parity, 1 stop bit
        write_tx(8'hA5);
        check("tx_busy_after_write", bus.tx_busy, 1);
        t = 0;
        while (tx !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("tx_start_seen", tx, 0);
        start_cyc = cyc;
        d = 0;
        while (tx === 1'b0 && d < 100) begin
            @(negedge clk);
            d++;
        end
        // start bit is 16 ticks from a free-running tick phase: 61..64 clk
        check("tx_start_len", (d >= 61 && d <= 64), 1);
        txexp = {1'b1, 1'b0, 8'hA5};
        for (int i = 0; i < 10; i++) begin
            wait_clk(32);
            check($sformatf("tx_bit%0d", i), tx, txexp[i]);
            if (i < 9) wait_clk(32);
        end
        t = 0;
        while (bus.tx_busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        busy_cyc = cyc;
        check("tx_busy_fall", busy_cyc - start_cyc, d + 640);
        check("tx_idle_high", tx, 1);

        // RX 0x3C, odd parity, correct parity bit
        parity_mode = 2'b10;
        rx_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        check("rx_odd_ok_empty", bus.rx_empty, 0);
        check("rx_odd_ok_data", bus.r_data, 8'h3C);
        check("rx_odd_ok_perr", bus.parity_err, 0);
        pop_rx();
        check("rx_odd_ok_popped", bus.rx_empty, 1);

        // RX 0x3C, odd parity, wrong parity bit
        rx_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        check("rx_odd_bad_perr", bus.parity_err, 1);
        check("rx_odd_bad_data", bus.r_data, 8'h3C);
        pop_rx();
        clear_errors();
        check("perr_cleared", bus.parity_err, 0);

        // framing error, no parity
        parity_mode = 2'b00;
        rx_frame(8'h55, 1'b0, 1'b0, 1'b0);
        check("fe_set", bus.frame_err, 1);
        check("fe_pe_clear", bus.parity_err, 0);
        check("fe_data", bus.r_data, 8'h55);
        pop_rx();
        check("fe_single_push", bus.rx_empty, 1);
        clear_errors();
        check("fe_errs_cleared", {bus.frame_err, bus.parity_err, bus.overrun}, 0);

        // overrun: five frames into a four-word FIFO
        for (int i = 1; i <= 5; i++) begin
            rx_frame(8'(i), 1'b0, 1'b0, 1'b1);
            if (i == 4) check("ovr_not_yet", bus.overrun, 0);
        end
        check("ovr_set", bus.overrun, 1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovr_read%0d", i), bus.r_data, 32'(i));
            pop_rx();
        end
        check("ovr_drained", bus.rx_empty, 1);
        clear_errors();

        // glitch: rx low for 3 ticks
        rx = 1'b0;
        wait_clk(12);
        rx = 1'b1;
        wait_clk(150);
        check("glitch_no_push", bus.rx_empty, 1);
        check("glitch_no_err", {bus.frame_err, bus.parity_err, bus.overrun}, 0);

        // asynchronous reset in the middle of a TX frame
        write_tx(8'h5A);
        wait_clk(200);
        check("midtx_busy", bus.tx_busy, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", bus.tx_busy, 0);
        wait_clk(2);
        reset = 1'b0;
        wait_clk(200);
        check("after_rst_tx_idle", tx, 1);

`ifdef UART_LOOPBACK_EN
        loopback    = 1'b1;
        parity_mode = 2'b00;
        write_tx(8'hC3);
        t      = 0;
        tx_low = 0;
        while (bus.rx_empty && t < 1500) begin
            if (tx !== 1'b1) tx_low++;
            @(negedge clk);
            t++;
        end
        check("lb_received", bus.rx_empty, 0);
        check("lb_tx_held_high", tx_low, 0);
        check("lb_data", bus.r_data, 8'hC3);
        check("lb_no_err", {bus.frame_err, bus.parity_err, bus.overrun}, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
- Second-generation UART core for the DDS control link: baud generator, 16x-oversampling receiver, transmitter and RX/TX FIFOs in one block.
- Adds run-time baud divisor, parity (none/even/odd), 1 or 2 stop bits, and sticky error reporting (framing, parity, overrun).
- Sits between the board RX/TX pins and the command-parser FSM.

Parameters:
- DBIT, 8, data bits per frame (5..8); the data bus width.
- FIFO_W, 2, address bits of each FIFO; depth = 2^FIFO_W words.
- DVSR_BIT, 16, width of the run-time divisor port.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high reset.
- dvsr  in  DVSR_BIT  oversample tick period in clk cycles (100M/(16*baud)).
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
- stop2  in  1  0 = 1 stop bit (16 ticks), 1 = 2 stop bits (32 ticks).
- rx  in  1  serial input; idle high; synchronised internally by 2 flops.
- tx  out  1  serial output; idle high.
- wr_uart  in  1  push w_data into the TX FIFO.
- w_data  in  DBIT  TX data.
- tx_full  out  1  TX FIFO full.
- tx_busy  out  1  TX FSM not idle, or TX FIFO not empty.
- rd_uart  in  1  pop the RX FIFO.
- r_data  out  DBIT  RX FIFO head (first-word-fall-through).
- rx_empty  out  1  RX FIFO empty.
- frame_err, parity_err, overrun  out  1 each  sticky error flags.
- err_clr  in  1  clears all three error flags.

Behaviour:
- Reset (async, any time, including mid-frame):
  - tx=1, tx_busy=0, tx_full=0, rx_empty=1, r_data=0, all error flags 0.
  - FIFOs emptied, FSMs return to idle, baud counter cleared.
- Baud tick:
  - Counter runs 0..eff-1, where eff = max(dvsr, 2); one-cycle tick when count = eff-1.
  - A dvsr change takes effect at the next counter wrap.
- Frame config: parity_mode and stop2 are latched per frame (TX at start-bit entry, RX at start detect); changing them mid-frame has no effect on that frame.
- TX FSM: IDLE -> START -> DATA -> PARITY (only if parity enabled) -> STOP -> IDLE.
  - Leaves IDLE on the first clk where the FIFO is non-empty; FIFO head is loaded into the shift register.
  - Every bit lasts 16 ticks; data is sent LSB first.
  - Parity bit: XOR of the data (even) or its inverse (odd).
  - Stop lasts 16 or 32 ticks.
  - FIFO pop is a one-clk pulse on STOP exit; the next frame starts back-to-back with no extra idle bit.
- RX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - START: on a falling synchronised rx, wait 7 ticks and resample. If rx is high, the start is a glitch: return to IDLE and push nothing.
  - DATA, PARITY and STOP bits are each sampled on the 16th tick after the previous sample.
  - Only the first stop bit is checked; the FSM returns to IDLE after 16 stop ticks, even when stop2=1.
  - Stop sample 0: set frame_err; the byte is still pushed.
  - Parity mismatch: set parity_err; the byte is still pushed.
  - Push is a one-clk pulse at STOP exit.
  - If the RX FIFO is full at push: the byte is dropped, overrun is set, and FIFO contents are unchanged.
- Error flags:
  - Set and clear in the same clk: set wins.
  - err_clr has no other side effect.
- FIFOs:
  - Write when full is ignored; read when empty is ignored.
  - Simultaneous rd+wr when full: both happen and the count is unchanged.
  - Simultaneous rd+wr when empty: the write happens and the read is ignored.
  - Pointers wrap modulo 2^FIFO_W.
  - r_data updates the clk after a pop or after a write into an empty FIFO.
- DBIT<8: the upper bits of r_data are not present, because the bus is DBIT wide.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, the RX synchroniser input is the internal tx and the tx pin is held at 1.
  - Switching loopback mid-frame may corrupt that frame only.
- Undefined:
  - No loopback port.
  - rx pin always feeds the receiver; tx pin always driven by the TX FSM.

Test Plan:
- TX even parity: dvsr=4 (64 clk/bit), parity_mode=01, stop2=0, write 0xA5.
  - tx low for 64 clk, then bits 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - tx_busy falls 704 clk after start-bit begin.
- RX odd parity: dvsr=4, parity_mode=10, drive a frame of 0x3C with parity bit 1.
  - rx_empty falls, r_data=0x3C, parity_err=0.
  - Repeat with parity bit 0: parity_err=1, r_data=0x3C.
- Framing: drive 0x55 with stop bit 0.
  - frame_err=1, byte 0x55 pushed.
  - err_clr pulse -> all error flags 0.
- Overrun: FIFO_W=2, receive 0x01..0x05 without reading.
  - overrun=1 after the 5th frame.
  - Reads return 0x01,0x02,0x03,0x04, then rx_empty=1.
- Glitch and reset: rx low for 3 ticks -> no push, rx_empty stays 1.
  - Assert reset mid-TX-frame -> tx=1 and tx_busy=0 immediately, with no clk edge required.
- Loopback (UART_LOOPBACK_EN, loopback=1): write 0xC3.
  - Same byte read back with no errors; tx pin held at 1 throughout.
